wb_ram_slave: RTL and testbench

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

---
 rtl/wb_ram_slave.sv | 163 ++++++++++++++++
 tb/tb_wb_ram_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone classic single-port RAM slave with configurable wait states.
// Out-of-window and misaligned accesses terminate with err and have no side effects.
module wb_ram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        wb_cyc_in,
   input  logic        wb_stb_in,
   input  logic        wb_we_in,
   input  logic [31:0] wb_adr_in,
   input  logic [31:0] wb_dat_in,
   input  logic [3:0]  wb_sel_in,
   output logic [31:0] wb_dat_out,
   output logic        wb_ack_out,
   output logic        wb_err_out
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WS_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI_BOUND = LO_BOUND + 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] rdat_q, rdat_d;

   logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

   logic          req_valid;
   logic          go_resp;
   logic          mem_we;
   logic [31:0]   req_adr;
   logic [31:0]   req_wdat;
   logic [3:0]    req_sel;
   logic          req_we;
   logic          req_err;
   logic [AW-1:0] word_idx;

   assign req_valid = wb_cyc_in & wb_stb_in;

   // With zero wait states the response edge is the sampling edge, so use the live bus.
   always_comb begin
      req_adr  = adr_q;
      req_wdat = wdat_q;
      req_sel  = sel_q;
      req_we   = we_q;
      if (state_q == ST_IDLE) begin
         req_adr  = wb_adr_in;
         req_wdat = wb_dat_in;
         req_sel  = wb_sel_in;
         req_we   = wb_we_in;
      end
   end

   assign req_err  = (req_adr[1:0] != 2'b00) ||
                     ({1'b0, req_adr} < LO_BOUND) ||
                     ({1'b0, req_adr} >= HI_BOUND);
   assign word_idx = AW'((req_adr - BASE_ADDR) >> 2);

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= 32'h0;
         wdat_q  <= 32'h0;
         sel_q   <= 4'h0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      go_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               adr_d  = wb_adr_in;
               wdat_d = wb_dat_in;
               sel_d  = wb_sel_in;
               we_d   = wb_we_in;
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!wb_cyc_in) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack_d  = 1'b0;
      err_d  = 1'b0;
      rdat_d = rdat_q;
      mem_we = 1'b0;
      if (go_resp) begin
         if (req_err) begin
            err_d = 1'b1;
         end else begin
            ack_d = 1'b1;
            if (req_we) mem_we = ~reset_in;
            else        rdat_d = mem_q[word_idx];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (req_sel[b]) mem_q[word_idx][8*b +: 8] <= req_wdat[8*b +: 8];
         end
      end
   end

   assign wb_dat_out = rdat_q;
   assign wb_ack_out = ack_q;
   assign wb_err_out = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (zero wait states, three wait states,
// high base address) driven from a vector table plus multi-cycle sequences.
module tb_wb_ram_slave;

   logic        clk;
   logic [2:0]  rst;
   logic [2:0]  cyc, stb, we;
   logic [31:0] adr  [3];
   logic [31:0] wdat [3];
   logic [3:0]  sel  [3];
   logic [31:0] rdat [3];
   logic [2:0]  ack, err;

   int total = 0;
   int bad   = 0;

   wb_ram_slave #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
      .clk_in(clk), .reset_in(rst[0]), .wb_cyc_in(cyc[0]), .wb_stb_in(stb[0]),
      .wb_we_in(we[0]), .wb_adr_in(adr[0]), .wb_dat_in(wdat[0]), .wb_sel_in(sel[0]),
      .wb_dat_out(rdat[0]), .wb_ack_out(ack[0]), .wb_err_out(err[0]));

   wb_ram_slave #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
      .clk_in(clk), .reset_in(rst[1]), .wb_cyc_in(cyc[1]), .wb_stb_in(stb[1]),
      .wb_we_in(we[1]), .wb_adr_in(adr[1]), .wb_dat_in(wdat[1]), .wb_sel_in(sel[1]),
      .wb_dat_out(rdat[1]), .wb_ack_out(ack[1]), .wb_err_out(err[1]));

   wb_ram_slave #(.BASE_ADDR(32'hFFFF_F000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_hi (
      .clk_in(clk), .reset_in(rst[2]), .wb_cyc_in(cyc[2]), .wb_stb_in(stb[2]),
      .wb_we_in(we[2]), .wb_adr_in(adr[2]), .wb_dat_in(wdat[2]), .wb_sel_in(sel[2]),
      .wb_dat_out(rdat[2]), .wb_ack_out(ack[2]), .wb_err_out(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   typedef struct {
      int          d;
      bit          w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  s;
      logic [1:0]  eresp;   // {ack, err}
      int          elat;
      logic [31:0] erd;
   } vec_t;

   vec_t vt [22];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output logic [1:0] resp, output int lat,
                       output logic [31:0] rd);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
      resp = 2'b00;
      lat  = 0;
      while (resp == 2'b00 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         stb[d] = 1'b0;
         resp = {ack[d], err[d]};
      end
      cyc[d] = 1'b0;
      rd = rdat[d];
      @(posedge clk); #1;
      chk("pulse_end", {62'b0, ack[d], err[d]}, 64'h0);
   endtask

   logic [1:0]  resp;
   int          lat;
   logic [31:0] rd;
   logic [9:0]  pat;
   logic        flag;

   initial begin
      vt[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b10, 1, 32'h0000_0000};
      vt[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 2'b10, 1, 32'hDEAD_BEEF};
      vt[2]  = '{0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'hF, 2'b10, 1, 32'hDEAD_BEEF};
      vt[3]  = '{0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 2'b10, 1, 32'hDEAD_BEEF};
      vt[4]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 2'b10, 1, 32'hAA22_CC44};
      vt[5]  = '{0, 1'b0, 32'h0000_0012, 32'h0,         4'hF, 2'b01, 1, 32'hAA22_CC44};
      vt[6]  = '{0, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 2'b01, 1, 32'hAA22_CC44};
      vt[7]  = '{0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 2'b10, 1, 32'hAA22_CC44};
      vt[8]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 2'b10, 1, 32'hAA22_CC44};
      vt[9]  = '{0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 2'b10, 1, 32'hAA22_CC44};
      vt[10] = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 2'b10, 1, 32'h1234_5678};
      vt[11] = '{0, 1'b1, 32'h0000_1000, 32'h5555_5555, 4'hF, 2'b01, 1, 32'h1234_5678};
      vt[12] = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 2'b10, 1, 32'h0000_0000};
      vt[13] = '{1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 2'b10, 4, 32'h0000_0000};
      vt[14] = '{1, 1'b0, 32'h0000_0030, 32'h0,         4'hF, 2'b10, 4, 32'hCAFE_F00D};
      vt[15] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 2'b10, 4, 32'h0000_0000};
      vt[16] = '{1, 1'b0, 32'h0000_0012, 32'h0,         4'hF, 2'b01, 4, 32'h0000_0000};
      vt[17] = '{2, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, 2'b10, 1, 32'h0000_0000};
      vt[18] = '{2, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 2'b10, 1, 32'hA5A5_A5A5};
      vt[19] = '{2, 1'b0, 32'hFFFF_EFFC, 32'h0,         4'hF, 2'b01, 1, 32'hA5A5_A5A5};
      vt[20] = '{2, 1'b0, 32'hFFFF_F000, 32'h0,         4'hF, 2'b10, 1, 32'h0000_0000};
      vt[21] = '{2, 1'b1, 32'hFFFF_F002, 32'h7777_7777, 4'hF, 2'b01, 1, 32'h0000_0000};

      rst = 3'b111; cyc = '0; stb = '0; we = '0;
      for (int i = 0; i < 3; i++) begin
         adr[i] = '0; wdat[i] = '0; sel[i] = '0;
      end
      #12;
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_outputs_%0d", i), {30'b0, ack[i], err[i], rdat[i]}, 64'h0);
      #10 rst = 3'b000;
      @(posedge clk); #1;

      for (int i = 0; i < 22; i++) begin
         xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].s, resp, lat, rd);
         chk($sformatf("v%0d_resp", i), 64'(resp), 64'(vt[i].eresp));
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].elat));
         chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].erd));
      end

      // Continuous request, zero wait states: one ack every second cycle.
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; sel[0] = 4'hF;
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         pat[i] = ack[0];
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      chk("b2b_ws0_pattern", 64'(pat), 64'h15);
      chk("b2b_ws0_rdata", 64'(rdat[0]), 64'hDEAD_BEEF);

      // Continuous request, three wait states: ack every fifth cycle.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h30; sel[1] = 4'hF;
      pat = '0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         pat[i] = ack[1];
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(posedge clk); #1;
      chk("b2b_ws3_pattern", 64'(pat), 64'h108);
      chk("b2b_ws3_rdata", 64'(rdat[1]), 64'hCAFE_F00D);

      // Abort: cyc dropped while waiting.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h0;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      flag = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         flag = flag | ack[1] | err[1];
      end
      chk("abort_no_resp", 64'(flag), 64'h0);
      chk("abort_rdata_held", 64'(rdat[1]), 64'hCAFE_F00D);
      xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, resp, lat, rd);
      chk("after_abort_resp", 64'(resp), 64'h2);
      chk("after_abort_latency", 64'(lat), 64'd4);

      // Reset mid-cycle while a write to 0x30 is waiting.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; wdat[1] = 32'h0BAD_F00D;
      @(posedge clk); #1;
      stb[1] = 1'b0;
      @(posedge clk); #3;
      rst[1] = 1'b1;
      #1;
      chk("async_reset_wait", {30'b0, ack[1], err[1], rdat[1]}, 64'h0);
      cyc[1] = 1'b0; we[1] = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst[1] = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, resp, lat, rd);
      chk("reset_cancel_resp", 64'(resp), 64'h2);
      chk("reset_cancel_rdata", 64'(rd), 64'hCAFE_F00D);

      // Reset during the ack cycle, then a request waiting when reset lifts.
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h20;
      @(posedge clk); #1;
      chk("pre_reset_ack", {31'b0, ack[0], rdat[0]}, {31'b0, 1'b1, 32'hAA22_CC44});
      rst[0] = 1'b1;
      #1;
      chk("async_reset_resp", {30'b0, ack[0], err[0], rdat[0]}, 64'h0);
      adr[0] = 32'h10;
      @(posedge clk); #4;
      rst[0] = 1'b0;
      @(posedge clk); #1;
      stb[0] = 1'b0;
      chk("first_edge_after_reset", {31'b0, ack[0], rdat[0]}, {31'b0, 1'b1, 32'hDEAD_BEEF});
      cyc[0] = 1'b0;
      @(posedge clk); #1;
      chk("first_edge_pulse_end", {62'b0, ack[0], err[0]}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
